// File: rtl/aes_dec_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, with on-the-fly reverse key expansion
// starting from a K10 that is forward-expanded once per key load.
module aes_dec_iter #(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned BW = 128;
  localparam int unsigned RW = 4;

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_READY, S_DEC, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] k_q, k_d, k10_q, k10_d, st_q, st_d, rk_q, rk_d, out_data_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic          out_valid_d, ready_q, ready_d, key_ready_d;
  logic [BW-1:0] rk_nx, k_nx, t;

  // GF(2^8) arithmetic, polynomial 0x11b
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p, e;
    r = 8'h01;
    p = a;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [RW-1:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [BW-1:0] fwd_exp(input logic [BW-1:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [BW-1:0] inv_exp(input logic [BW-1:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h000000};
    return {n0, n1, n2, n3};
  endfunction

  // InvShiftRows fused with InvSubBytes; byte index is 4*column+row
  function automatic logic [BW-1:0] inv_shift_sub(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [BW-1:0] inv_mix(input logic [BW-1:0] s);
    logic [BW-1:0] o;
    logic [7:0]    a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign in_ready = ready_q & ~key_load;

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    k10_d       = k10_q;
    st_d        = st_q;
    rk_d        = rk_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    rk_nx       = inv_exp(rk_q, rcon(rnd_q));
    k_nx        = fwd_exp(k_q, rcon(rnd_q));
    t           = inv_shift_sub(st_q) ^ rk_nx;
    case (state_q)
      S_IDLE, S_READY: begin
        if (key_load) begin
          k_d     = key;
          rnd_d   = RW'(1);
          state_d = S_KEXP;
        end else if (state_q == S_READY && in_valid) begin
          st_d    = in_data ^ k10_q;
          rk_d    = k10_q;
          rnd_d   = RW'(10);
          state_d = S_DEC;
        end
      end
      S_KEXP: begin
        k_d   = k_nx;
        rnd_d = rnd_q + RW'(1);
        if (rnd_q == RW'(10)) begin
          k10_d   = k_nx;
          state_d = S_READY;
        end
      end
      S_DEC: begin
        st_d  = (rnd_q == RW'(1)) ? t : inv_mix(t);
        rk_d  = rk_nx;
        rnd_d = rnd_q - RW'(1);
        if (rnd_q == RW'(1)) begin
          out_data_d  = t;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (ZEROIZE) begin
            st_d       = '0;
            rk_d       = '0;
            out_data_d = '0;
          end
          state_d = S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d     = (state_d == S_READY);
    key_ready_d = (state_d == S_IDLE) || (state_d == S_READY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      k10_q     <= '0;
      st_q      <= '0;
      rk_q      <= '0;
      rnd_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ready_q   <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      k10_q     <= k10_d;
      st_q      <= st_d;
      rk_q      <= rk_d;
      rnd_q     <= rnd_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      ready_q   <= ready_d;
      key_ready <= key_ready_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter: known-answer vectors plus handshake, priority and reset cases.
module tb_aes_dec_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs[4];

  aes_dec_iter dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the expanded key ready
  task automatic load_key(input logic [127:0] k);
    int n;
    n = 0;
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("key_ready_before_load", 128'(key_ready), 128'(1));
    key_load = 1'b1;
    key      = k;
    @(posedge clk);
    @(negedge clk);
    key_load = 1'b0;
    n = 0;
    while (!key_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("key_ready_after_kexp", 128'(key_ready), 128'(1));
  endtask

  // Issues one block; returns at a negedge with out_valid high (or on timeout)
  task automatic send_block(input logic [127:0] ct, output logic [127:0] pt, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ct;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    pt = out_data;
  endtask

  task automatic recv_and_check(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_cleared"}, 128'(out_valid), 128'(0));
    chk({tag, "_zeroized"}, out_data, 128'(0));
    chk({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] pt, hold;
    int           lat;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h00000000000000000000000000000000, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'h00000000000000000000000000000000};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};

    rst = 1'b1; key_load = 1'b0; key = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("reset_key_ready", 128'(key_ready), 128'(1));
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", out_data, 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer vectors, each with a fresh key
    for (int i = 0; i < 4; i++) begin
      load_key(vecs[i].key);
      if (i == 1) chk("k10_vector2", dut.k10_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      send_block(vecs[i].ct, pt, lat);
      chk($sformatf("vec%0d_pt", i), pt, vecs[i].pt);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(11));
      recv_and_check($sformatf("vec%0d", i));
    end

    // Back-to-back blocks under one key, no reload
    load_key(vecs[0].key);
    for (int j = 0; j < 2; j++) begin
      send_block(vecs[0].ct, pt, lat);
      chk($sformatf("b2b%0d_pt", j), pt, vecs[0].pt);
      recv_and_check($sformatf("b2b%0d", j));
      chk($sformatf("b2b%0d_key_ready", j), 128'(key_ready), 128'(1));
    end

    // Backpressure: output held while the sink stalls
    send_block(vecs[0].ct, pt, lat);
    chk("bp_pt", pt, vecs[0].pt);
    hold = out_data;
    in_valid = 1'b1;
    in_data  = vecs[1].ct;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_valid_c%0d", c), 128'(out_valid), 128'(1));
      chk($sformatf("bp_data_c%0d", c), out_data, hold);
      chk($sformatf("bp_in_ready_c%0d", c), 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    recv_and_check("bp");

    // key_load beats in_valid in the same READY cycle
    key_load = 1'b1;
    key      = vecs[1].key;
    in_valid = 1'b1;
    in_data  = vecs[1].ct;
    #1;
    chk("prio_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    @(negedge clk);
    key_load = 1'b0;
    chk("prio_in_kexp_key_ready", 128'(key_ready), 128'(0));
    chk("prio_in_kexp_in_ready", 128'(in_ready), 128'(0));
    send_block(vecs[1].ct, pt, lat);
    chk("prio_new_key_pt", pt, vecs[1].pt);
    recv_and_check("prio");

    // Asynchronous reset in the middle of a decryption
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = vecs[1].ct;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_mid_round", 128'(dut.rnd_q), 128'(5));
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_nokey_in_ready_c%0d", c), 128'(in_ready), 128'(0));
      chk($sformatf("rst_nokey_out_valid_c%0d", c), 128'(out_valid), 128'(0));
    end
    in_valid = 1'b0;
    load_key(vecs[0].key);
    send_block(vecs[0].ct, pt, lat);
    chk("post_rst_pt", pt, vecs[0].pt);
    recv_and_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
